calc_key_sequencer: RTL and testbench
=====================================

# calc_key_sequencer

Operand-entry sequencer for the calculator datapath. It takes key strobes from the keypad decoder and accumulates decimal digits into two 8-bit operands. It latches the selected bitwise operation and, on "equals", presents `{op_a, op_b, op_sel}` to the 8-bit logic units (AND/OR/XOR/XNOR) through a valid/ready handshake. It is the stage directly upstream of the XOR/logic unit.

## Interface
- No parameters; width fixed at 8 bits.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: key strobe from the keypad decoder.
- `key_code` in 5: 0x00–0x09 digit; 0x10 AND, 0x11 OR, 0x12 XOR, 0x13 XNOR; 0x1E equals; 0x1F clear. All other codes are ignored.
- `key_ready` out 1: sequencer accepts a key this cycle.
- `op_a` out 8: operand A to the logic units.
- `op_b` out 8: operand B to the logic units.
- `op_sel` out 2: 0 AND, 1 OR, 2 XOR, 3 XNOR.
- `issue_valid` out 1: operands and operation are valid.
- `issue_ready` in 1: downstream accepts the operation.
- `entry_value` out 8: value currently being entered, for the display.
- `ovf` out 1: sticky flag, set when an entry saturated.

## Operation
- **States:** ENTER_A (reset state), ENTER_B, ISSUE.
- **Key acceptance:** a key is accepted when `key_valid && key_ready`. `key_ready` = (state != ISSUE) and is combinational from state, so it is 1 immediately after reset.
- **Digit d:** the active accumulator is A in ENTER_A and B in ENTER_B. Next value = acc*10 + d, computed at 12 bits. If the result exceeds 255, the accumulator becomes 255 and `ovf` is set.
- **Op key in ENTER_A:** latch `op_sel`, clear B, go to ENTER_B.
- **Op key in ENTER_B:** replace `op_sel`; B is kept and the state is unchanged. There is no chaining.
- **Equals:** ignored in ENTER_A. In ENTER_B it goes to ISSUE.
- **Clear (ENTER_A/ENTER_B):** A, B and `op_sel` go to 0, `ovf` goes to 0, state goes to ENTER_A.
- **In ISSUE:** all keys are refused, because `key_ready` = 0.
- **Handshake complete** (`issue_valid && issue_ready`): A and B go to 0, state goes to ENTER_A. `ovf` is unchanged.
- **`entry_value`:** equals A in ENTER_A, and B in ENTER_B and ISSUE.
- **`op_a`/`op_b`:** driven directly from the A/B registers at all times.

## Timing
- **Reset:** every register clears asynchronously. Values during reset: `op_a` = `op_b` = 0, `op_sel` = 0, `issue_valid` = 0, `entry_value` = 0, `ovf` = 0, state ENTER_A, `key_ready` = 1.
- **Key latency:** a key accepted at edge N is reflected in the registers and outputs after edge N.
- **Equals latency:** equals accepted at edge N gives `issue_valid` = 1 from edge N to the handshake edge, i.e. one cycle of latency.
- **Stability:** while `issue_valid` = 1, `op_a`, `op_b` and `op_sel` hold stable. `issue_valid` never drops without a handshake, except on reset.
- **Handshake at edge M:** `issue_valid` = 0 and `key_ready` = 1 after edge M. `issue_ready` may be held high permanently; this gives the minimum of one cycle in ISSUE.
- **Reset mid-ISSUE:** the operation is dropped; no handshake is owed.
- **Saturation:** saturation is reached in a single step. Further digits keep the accumulator at 255, and `ovf` stays set.

## Configuration
- **`CALC_SEQ_HEX_EN` defined:** key codes 0x0A–0x0F are hex digits, and accumulation is acc*16 + d with the same saturation and `ovf` rule.
- **`CALC_SEQ_HEX_EN` undefined:** codes 0x0A–0x0F are ignored, and accumulation is decimal (acc*10 + d).

## Structure
- **Package `calc_pkg`:** key-code constants, `op_sel` encodings, state encodings, and the operand width constant (8).
- **Sub-module `calc_digit_accum`:** combinational, mapping (acc[7:0], digit[3:0]) to (next[7:0], sat). The radix is selected by `CALC_SEQ_HEX_EN`. The FSM and all registers stay in `calc_key_sequencer`.

## Test plan
- **Basic XOR issue:** keys 1,2,XOR,1,0,= with `issue_ready` = 1 → one `issue_valid` cycle with `op_a` = 12, `op_b` = 10, `op_sel` = 2; downstream XOR = 6; state returns to ENTER_A with `entry_value` = 0.
- **Saturation and clear:** keys 3,0,0 → `entry_value` = 255, `ovf` = 1. Then clear → `entry_value` = 0, `ovf` = 0.
- **Back-pressure:** 5,OR,3,= with `issue_ready` = 0 for 5 cycles → `issue_valid`, `op_a` = 5, `op_b` = 3 and `op_sel` = 1 all stable; `key_ready` = 0; digit strobes during these cycles have no effect. Raising `issue_ready` completes the handshake in one cycle.
- **Equals and op replacement:** equals in ENTER_A → no state change. Then 7,AND,XNOR,2,= → `op_sel` = 3, `op_a` = 7, `op_b` = 2.
- **Reset mid-issue:** assert `rst_n` = 0 mid-ISSUE → all outputs 0 at once, state ENTER_A, `key_ready` = 1 after release.
- **Hex entry (`CALC_SEQ_HEX_EN` only):** keys 0x0A,0x0F → `entry_value` = 0xAF. Adding key 1 → 0xFF with `ovf` = 1.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: key codes, operation
// and state encodings, operand width and the digit-key decoder.
// Optional feature macro: CALC_SEQ_HEX_EN (accepts hex digit keys 0x0A-0x0F).
package calc_pkg;

    localparam int OPERAND_W = 8;

    localparam logic [4:0] KEY_AND    = 5'h10;
    localparam logic [4:0] KEY_OR     = 5'h11;
    localparam logic [4:0] KEY_XOR    = 5'h12;
    localparam logic [4:0] KEY_XNOR   = 5'h13;
    localparam logic [4:0] KEY_EQUALS = 5'h1E;
    localparam logic [4:0] KEY_CLEAR  = 5'h1F;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } op_sel_e;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ISSUE   = 2'd2
    } seq_state_e;

    // Digit keys live in the lower half of the code space; decimal builds
    // only accept 0-9, so 0x0A-0x0F fall through as ignored codes.
    function automatic logic isDigitKey(input logic [4:0] code);
`ifdef CALC_SEQ_HEX_EN
        return code[4] == 1'b0;
`else
        return (code[4] == 1'b0) && (code[3:0] <= 4'd9);
`endif
    endfunction

    function automatic logic isOpKey(input logic [4:0] code);
        return code inside {KEY_AND, KEY_OR, KEY_XOR, KEY_XNOR};
    endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Key-strobe and issue handshake bundle between keypad decoder, sequencer
// and the downstream logic units. The sequencer uses the slave modport; the
// environment around it (keypad side and logic-unit side) uses master.
interface calc_key_sequencer_if;
    import calc_pkg::*;

    logic                 key_valid;
    logic [4:0]           key_code;
    logic                 key_ready;
    logic [OPERAND_W-1:0] op_a;
    logic [OPERAND_W-1:0] op_b;
    logic [1:0]           op_sel;
    logic                 issue_valid;
    logic                 issue_ready;

    modport slave (
        input  key_valid, key_code, issue_ready,
        output key_ready, op_a, op_b, op_sel, issue_valid
    );

    modport master (
        output key_valid, key_code, issue_ready,
        input  key_ready, op_a, op_b, op_sel, issue_valid
    );

endinterface

// File: rtl/calc_digit_accum.sv
// Combinational digit accumulator: next = acc*radix + digit, saturating at 255.
// Radix is 16 when CALC_SEQ_HEX_EN is defined, otherwise 10.
module calc_digit_accum
    import calc_pkg::*;
(
    input  logic [OPERAND_W-1:0] acc_i,
    input  logic [3:0]           digit_i,
    output logic [OPERAND_W-1:0] next_o,
    output logic                 sat_o
);

    logic [11:0] wide;

    // Twelve bits hold the worst case (255*16+15) so the overflow test is exact.
    always_comb begin
        wide = '0;
`ifdef CALC_SEQ_HEX_EN
        wide = {acc_i, 4'd0} + {8'd0, digit_i};
`else
        wide = ({4'd0, acc_i} * 12'd10) + {8'd0, digit_i};
`endif
        sat_o  = wide > 12'd255;
        next_o = sat_o ? 8'hFF : wide[7:0];
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Operand-entry sequencer: collects two operands and an operation from key
// strobes and hands {op_a, op_b, op_sel} downstream over valid/ready.
// Optional feature macro: CALC_SEQ_HEX_EN (hex digit entry, via calc_pkg and
// calc_digit_accum).
module calc_key_sequencer
    import calc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    calc_key_sequencer_if.slave  bus,
    output logic [OPERAND_W-1:0] entry_value,
    output logic                 ovf
);

    seq_state_e           state_q;
    logic [OPERAND_W-1:0] opA_q;
    logic [OPERAND_W-1:0] opB_q;
    op_sel_e              opSel_q;
    logic                 ovf_q;

    logic                 keyFire;
    logic                 isDigit;
    logic                 isOp;
    logic                 isEquals;
    logic                 isClear;
    logic [OPERAND_W-1:0] accIn;
    logic [OPERAND_W-1:0] accNext_d;
    logic                 accSat_d;

    assign bus.key_ready   = (state_q != ISSUE);
    assign bus.issue_valid = (state_q == ISSUE);
    assign bus.op_a        = opA_q;
    assign bus.op_b        = opB_q;
    assign bus.op_sel      = opSel_q;
    assign entry_value     = (state_q == ENTER_A) ? opA_q : opB_q;
    assign ovf             = ovf_q;

    assign keyFire  = bus.key_valid && bus.key_ready;
    assign isDigit  = isDigitKey(bus.key_code);
    assign isOp     = isOpKey(bus.key_code);
    assign isEquals = (bus.key_code == KEY_EQUALS);
    assign isClear  = (bus.key_code == KEY_CLEAR);
    assign accIn    = (state_q == ENTER_B) ? opB_q : opA_q;

    calc_digit_accum uAccum (
        .acc_i   (accIn),
        .digit_i (bus.key_code[3:0]),
        .next_o  (accNext_d),
        .sat_o   (accSat_d)
    );

    // Entry FSM: digits feed the active operand, op/equals/clear steer the state, ISSUE waits for the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTER_A;
            opA_q   <= '0;
            opB_q   <= '0;
            opSel_q <= OP_AND;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ENTER_A, ENTER_B: begin
                    if (keyFire) begin
                        if (isDigit) begin
                            if (state_q == ENTER_A) opA_q <= accNext_d;
                            else                    opB_q <= accNext_d;
                            if (accSat_d) ovf_q <= 1'b1;
                        end else if (isOp) begin
                            opSel_q <= op_sel_e'(bus.key_code[1:0]);
                            if (state_q == ENTER_A) begin
                                opB_q   <= '0;
                                state_q <= ENTER_B;
                            end
                        end else if (isEquals) begin
                            if (state_q == ENTER_B) state_q <= ISSUE;
                        end else if (isClear) begin
                            opA_q   <= '0;
                            opB_q   <= '0;
                            opSel_q <= OP_AND;
                            ovf_q   <= 1'b0;
                            state_q <= ENTER_A;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.issue_ready) begin
                        opA_q   <= '0;
                        opB_q   <= '0;
                        state_q <= ENTER_A;
                    end
                end
                default: state_q <= ENTER_A;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer: directed scenarios from the
// operating description plus a randomized key stream, all compared against
// an arithmetic reference model of operand entry.
module tb_calc_key_sequencer;
    import calc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] entry_value;
    logic       ovf;

    int checkCount = 0;
    int errCount   = 0;

    // Reference model: phase 0 = entering A, 1 = entering B, 2 = waiting to issue.
    int mA, mB, mOp, mPhase;
    bit mOvf;

    calc_key_sequencer_if bus();

    calc_key_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .entry_value (entry_value),
        .ovf         (ovf)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int modelRadix();
`ifdef CALC_SEQ_HEX_EN
        return 16;
`else
        return 10;
`endif
    endfunction

    function automatic void modelReset();
        mA = 0; mB = 0; mOp = 0; mPhase = 0; mOvf = 0;
    endfunction

    function automatic void modelStep(input logic kv, input logic [4:0] kc, input logic ir);
        int code = int'(kc);
        int v;
        if (mPhase == 2) begin
            if (ir) begin mA = 0; mB = 0; mPhase = 0; end
        end else if (kv) begin
            if (code < modelRadix()) begin
                v = ((mPhase == 0) ? mA : mB) * modelRadix() + code;
                if (v > 255) begin v = 255; mOvf = 1; end
                if (mPhase == 0) mA = v; else mB = v;
            end else if (code >= 16 && code <= 19) begin
                mOp = code - 16;
                if (mPhase == 0) begin mB = 0; mPhase = 1; end
            end else if (code == 30) begin
                if (mPhase == 1) mPhase = 2;
            end else if (code == 31) begin
                modelReset();
            end
        end
    endfunction

    task automatic compareAll(input string ctx);
        checkOutput({ctx, ".op_a"},        32'(bus.op_a),        32'(mA));
        checkOutput({ctx, ".op_b"},        32'(bus.op_b),        32'(mB));
        checkOutput({ctx, ".op_sel"},      32'(bus.op_sel),      32'(mOp));
        checkOutput({ctx, ".issue_valid"}, 32'(bus.issue_valid), 32'(mPhase == 2));
        checkOutput({ctx, ".key_ready"},   32'(bus.key_ready),   32'(mPhase != 2));
        checkOutput({ctx, ".entry_value"}, 32'(entry_value),     32'((mPhase == 0) ? mA : mB));
        checkOutput({ctx, ".ovf"},         32'(ovf),             32'(mOvf));
    endtask

    // One clock: drive inputs mid-cycle, advance the model at the edge, sample 1ns later.
    task automatic applyStimulus(input string ctx, input logic kv, input logic [4:0] kc, input logic ir);
        @(negedge clk);
        bus.key_valid   = kv;
        bus.key_code    = kc;
        bus.issue_ready = ir;
        @(posedge clk);
        modelStep(kv, kc, ir);
        #1;
        compareAll(ctx);
    endtask

    task automatic pressKeys(input string ctx, input logic [4:0] keys[$], input logic ir);
        foreach (keys[i]) applyStimulus(ctx, 1'b1, keys[i], ir);
    endtask

    function automatic logic [4:0] randKey();
        int r = $urandom_range(0, 99);
        if (r < 55)      return 5'($urandom_range(0, 9));
        else if (r < 70) return 5'(16 + $urandom_range(0, 3));
        else if (r < 80) return KEY_EQUALS;
        else if (r < 84) return KEY_CLEAR;
        else             return 5'($urandom_range(0, 31));
    endfunction

    // Stimulus sequence: reset, directed scenarios, random stream, summary.
    initial begin
        bus.key_valid   = 1'b0;
        bus.key_code    = 5'd0;
        bus.issue_ready = 1'b0;
        rst_n           = 1'b0;
        modelReset();
        #3;
        compareAll("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset.release_ready", 32'(bus.key_ready), 32'd1);

        // Basic XOR issue.
        pressKeys("xor", '{5'd1, 5'd2, KEY_XOR, 5'd1, 5'd0, KEY_EQUALS}, 1'b1);
        checkOutput("xor.valid",  32'(bus.issue_valid), 32'd1);
        checkOutput("xor.op_a",   32'(bus.op_a),        32'd12);
        checkOutput("xor.op_b",   32'(bus.op_b),        32'd10);
        checkOutput("xor.op_sel", 32'(bus.op_sel),      32'd2);
        checkOutput("xor.result", 32'(bus.op_a ^ bus.op_b), 32'd6);
        applyStimulus("xor.hs", 1'b0, 5'd0, 1'b1);
        checkOutput("xor.after_valid", 32'(bus.issue_valid), 32'd0);
        checkOutput("xor.after_entry", 32'(entry_value),     32'd0);

        // Saturation then clear.
        pressKeys("sat", '{5'd3, 5'd0, 5'd0}, 1'b0);
        checkOutput("sat.entry", 32'(entry_value), 32'd255);
        checkOutput("sat.ovf",   32'(ovf),         32'd1);
        applyStimulus("sat.more", 1'b1, 5'd7, 1'b0);
        checkOutput("sat.hold", 32'(entry_value), 32'd255);
        applyStimulus("clr", 1'b1, KEY_CLEAR, 1'b0);
        checkOutput("clr.entry", 32'(entry_value), 32'd0);
        checkOutput("clr.ovf",   32'(ovf),         32'd0);

        // Back-pressure with ignored digit strobes.
        pressKeys("bp", '{5'd5, KEY_OR, 5'd3, KEY_EQUALS}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("bp.stall", 1'b1, 5'($urandom_range(0, 9)), 1'b0);
            checkOutput("bp.valid",  32'(bus.issue_valid), 32'd1);
            checkOutput("bp.op_a",   32'(bus.op_a),        32'd5);
            checkOutput("bp.op_b",   32'(bus.op_b),        32'd3);
            checkOutput("bp.op_sel", 32'(bus.op_sel),      32'd1);
            checkOutput("bp.ready",  32'(bus.key_ready),   32'd0);
        end
        applyStimulus("bp.hs", 1'b0, 5'd0, 1'b1);
        checkOutput("bp.done", 32'(bus.issue_valid), 32'd0);

        // Equals in ENTER_A is ignored; second op key replaces the first.
        applyStimulus("eqA", 1'b1, KEY_EQUALS, 1'b1);
        checkOutput("eqA.valid", 32'(bus.issue_valid), 32'd0);
        pressKeys("rep", '{5'd7, KEY_AND, KEY_XNOR, 5'd2, KEY_EQUALS}, 1'b0);
        checkOutput("rep.op_sel", 32'(bus.op_sel), 32'd3);
        checkOutput("rep.op_a",   32'(bus.op_a),   32'd7);
        checkOutput("rep.op_b",   32'(bus.op_b),   32'd2);
        applyStimulus("rep.hs", 1'b0, 5'd0, 1'b1);

        // Reset while an operation is pending.
        pressKeys("rst", '{5'd4, KEY_AND, 5'd9, KEY_EQUALS}, 1'b0);
        applyStimulus("rst.wait", 1'b0, 5'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        compareAll("rst.async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst.ready", 32'(bus.key_ready), 32'd1);

`ifdef CALC_SEQ_HEX_EN
        // Hex digit entry and single-step saturation.
        pressKeys("hex", '{5'h0A, 5'h0F}, 1'b0);
        checkOutput("hex.entry", 32'(entry_value), 32'hAF);
        applyStimulus("hex.sat", 1'b1, 5'h01, 1'b0);
        checkOutput("hex.sat_entry", 32'(entry_value), 32'hFF);
        checkOutput("hex.sat_ovf",   32'(ovf),         32'd1);
`else
        // Hex codes are ignored in decimal builds.
        pressKeys("dec", '{5'd4, 5'h0A, 5'h0F}, 1'b0);
        checkOutput("dec.entry", 32'(entry_value), 32'd4);
`endif
        applyStimulus("pre_rand.clr", 1'b1, KEY_CLEAR, 1'b0);

        // Randomized key stream with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 9) < 7), randKey(), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
